// File: rtl/hdmi_fetch_ctrl_if.sv
// hdmi_fetch_ctrl_if: burst read request bus between the line-fetch scheduler and the DDR2 read master.
interface hdmi_fetch_ctrl_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_len;
  logic              mem_ack;
  logic              mem_rd_last;
  modport master (output mem_req, mem_addr, mem_len, input mem_ack, mem_rd_last);
  modport slave (input mem_req, mem_addr, mem_len, output mem_ack, mem_rd_last);
endinterface

// File: rtl/hdmi_fetch_ctrl.sv
// hdmi_fetch_ctrl: splits each frame-buffer line into burst reads, prefetching at most two lines ahead.
// Define HDMI_FETCH_DBLBUF_EN to enable frame-boundary swapping between fb_base_a and fb_base_b.
module hdmi_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int BURST_LEN = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [10:0]       hres,
  input  logic [9:0]        vres,
  input  logic [15:0]       stride,
  input  logic [ADDR_W-1:0] fb_base_a,
  input  logic [ADDR_W-1:0] fb_base_b,
  input  logic              fb_swap_req,
  output logic              fb_swap_ack,
  output logic              fb_active,
  input  logic              read_go,
  input  logic              read_next_line,
  input  logic              read_done,
  hdmi_fetch_ctrl_if.master mem,
  output logic              busy,
  output logic              underrun,
  output logic [9:0]        line_count
);
  typedef enum logic [2:0] {IDLE, ISSUE, DATA, LINE_END, WAIT_SLOT, DRAIN} state_t;
  localparam logic [10:0] BL = 11'(BURST_LEN);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN * 8);
  state_t state;
  logic [ADDR_W-1:0] line_addr, base, next_line;
  logic [10:0] beats, rem, src, len_c;
  logic [1:0] lines_ready, lr_next;
  logic done_pend, restart_pend, frame_start, lr_inc, lr_dec;
  assign beats = {1'b0, hres[10:1]} + 11'(hres[0]);
  assign frame_start = state == DATA ? mem.mem_rd_last && (read_go || restart_pend)
                     : state == ISSUE ? read_go && !mem.mem_ack : read_go;
  // rem counts beats of the current line not yet requested
  assign src = (state == DATA && !frame_start) ? rem : beats;
  assign len_c = src > BL ? BL : src;
  assign next_line = line_addr + ADDR_W'(stride);
  assign busy = state != IDLE;
  assign lr_inc = state == LINE_END;
  assign lr_dec = read_next_line && (lines_ready != 2'd0 || lr_inc);
  assign lr_next = lines_ready + 2'(lr_inc) - 2'(lr_dec);
`ifdef HDMI_FETCH_DBLBUF_EN
  logic swap_pending;
  assign base = (fb_active ^ swap_pending) ? fb_base_b : fb_base_a;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      fb_active <= 1'b0;
      fb_swap_ack <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      fb_swap_ack <= frame_start && swap_pending;
      fb_active <= fb_active ^ (frame_start && swap_pending);
      swap_pending <= (swap_pending && !frame_start) || fb_swap_req;
    end
`else
  logic unused_swap;
  assign unused_swap = ^{fb_base_b, fb_swap_req};
  assign base = fb_base_a;
  assign fb_active = 1'b0;
  assign fb_swap_ack = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      lines_ready <= 2'd0;
      underrun <= 1'b0;
    end else if (frame_start) begin
      lines_ready <= 2'd0;
      underrun <= 1'b0;
    end else begin
      lines_ready <= lr_next;
      underrun <= underrun | (read_next_line && !lr_dec);
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      mem.mem_req <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_len <= '0;
      line_addr <= '0;
      rem <= '0;
      line_count <= '0;
      done_pend <= 1'b0;
      restart_pend <= 1'b0;
    end else if (frame_start) begin
      state <= ISSUE;
      mem.mem_req <= 1'b1;
      mem.mem_addr <= base;
      mem.mem_len <= 8'(len_c);
      line_addr <= base;
      rem <= src - len_c;
      line_count <= '0;
      done_pend <= 1'b0;
      restart_pend <= 1'b0;
    end else
      case (state)
        ISSUE:
          if (mem.mem_ack) begin
            state <= DATA;
            mem.mem_req <= 1'b0;
            done_pend <= read_done;
            restart_pend <= read_go;
          end else if (read_done) begin
            state <= IDLE;
            mem.mem_req <= 1'b0;
          end
        DATA: begin
          done_pend <= done_pend | read_done;
          restart_pend <= restart_pend | read_go;
          if (mem.mem_rd_last) begin
            if (done_pend || read_done) begin
              state <= IDLE;
              done_pend <= 1'b0;
            end else if (rem != 11'd0) begin
              state <= ISSUE;
              mem.mem_req <= 1'b1;
              mem.mem_addr <= mem.mem_addr + STEP;
              mem.mem_len <= 8'(len_c);
              rem <= src - len_c;
            end else
              state <= LINE_END;
          end
        end
        LINE_END: begin
          line_count <= line_count + 10'd1;
          line_addr <= next_line;
          if (read_done)
            state <= IDLE;
          else if (line_count + 10'd1 == vres)
            state <= DRAIN;
          else if (lr_next < 2'd2) begin
            state <= ISSUE;
            mem.mem_req <= 1'b1;
            mem.mem_addr <= next_line;
            mem.mem_len <= 8'(len_c);
            rem <= src - len_c;
          end else
            state <= WAIT_SLOT;
        end
        WAIT_SLOT:
          if (read_done)
            state <= IDLE;
          else if (lines_ready < 2'd2) begin
            state <= ISSUE;
            mem.mem_req <= 1'b1;
            mem.mem_addr <= line_addr;
            mem.mem_len <= 8'(len_c);
            rem <= src - len_c;
          end
        DRAIN:
          if (read_done)
            state <= IDLE;
        default: ;
      endcase
endmodule

// File: tb/tb_hdmi_fetch_ctrl.sv
// tb_hdmi_fetch_ctrl: directed frames against a burst scoreboard fed by a simple memory responder.
module tb_hdmi_fetch_ctrl;
  typedef struct {logic [31:0] addr; logic [7:0] len; int gap;} exp_t;
`ifdef HDMI_FETCH_DBLBUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif
  localparam logic [31:0] BASE_A = 32'h1000_0000;
  localparam logic [31:0] BASE_B = 32'h2000_0000;
  logic clock = 1'b0, reset = 1'b1;
  logic [10:0] hres = '0;
  logic [9:0] vres = '0;
  logic [15:0] stride = '0;
  logic fb_swap_req = 1'b0, fb_swap_ack, fb_active;
  logic read_go = 1'b0, read_next_line = 1'b0, read_done = 1'b0;
  logic busy, underrun;
  logic [9:0] line_count;
  exp_t q[$];
  bit mem_en = 1'b0;
  int lat = 0, nbursts = 0, cyc = 0, last_cyc = 0;
  int passed = 0, failed = 0, total = 0;

  hdmi_fetch_ctrl_if #(.ADDR_W(32)) m();

  hdmi_fetch_ctrl dut (
    .clock(clock), .reset(reset), .hres(hres), .vres(vres), .stride(stride),
    .fb_base_a(BASE_A), .fb_base_b(BASE_B), .fb_swap_req(fb_swap_req),
    .fb_swap_ack(fb_swap_ack), .fb_active(fb_active), .read_go(read_go),
    .read_next_line(read_next_line), .read_done(read_done), .mem(m),
    .busy(busy), .underrun(underrun), .line_count(line_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] base, input int strd, input int bts, input int lines);
    for (int l = 0; l < lines; l++) begin
      int left;
      left = bts;
      for (int b = 0; left > 0; b++) begin
        exp_t e;
        e.addr = base + 32'(l * strd) + 32'(b * 128);
        e.len = 8'(left > 16 ? 16 : left);
        e.gap = b > 0 ? 1 : (l > 0 ? 2 : 0);
        left -= 16;
        q.push_back(e);
      end
    end
  endtask

  task automatic wait_bursts(input int n);
    int t;
    t = 0;
    while (nbursts < n && t < 5000) begin
      step();
      t++;
    end
    check("burst_count", nbursts, n);
  endtask

  // memory model: accept each request at once, return last beat after lat cycles
  initial begin
    exp_t e;
    m.mem_ack = 1'b0;
    m.mem_rd_last = 1'b0;
    forever begin
      if (mem_en && m.mem_req === 1'b1) begin
        check("sb_has_entry", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("burst_addr", m.mem_addr, e.addr);
          check("burst_len", m.mem_len, e.len);
          if (e.gap != 0) check("issue_gap", cyc - last_cyc, e.gap);
        end
        m.mem_ack = 1'b1;
        step();
        m.mem_ack = 1'b0;
        check("req_drop_after_ack", m.mem_req, 0);
        repeat (lat) step();
        m.mem_rd_last = 1'b1;
        last_cyc = cyc;
        step();
        m.mem_rd_last = 1'b0;
        nbursts++;
      end else
        step();
    end
  end

  initial begin
    int t, nb, hits;
    logic [31:0] fb;
    #3 reset = 1'b0;
    #1;
    check("rst_mem_req", m.mem_req, 0);
    check("rst_mem_addr", m.mem_addr, 0);
    check("rst_mem_len", m.mem_len, 0);
    check("rst_busy", busy, 0);
    check("rst_fb_active", fb_active, 0);
    check("rst_line_count", line_count, 0);
    step();
    reset = 1'b1;
    mem_en = 1'b1;
    step();
    // frame A: 1280x720, nothing consumed, stalls after two lines
    hres = 11'd1280; vres = 10'd720; stride = 16'd5120;
    nb = nbursts;
    push_frame(BASE_A, 5120, 640, 2);
    read_go = 1'b1; step(); read_go = 1'b0;
    check("a_first_req", m.mem_req, 1);
    check("a_first_addr", m.mem_addr, BASE_A);
    check("a_busy", busy, 1);
    wait_bursts(nb + 10);
    fb_swap_req = 1'b1; step(); fb_swap_req = 1'b0;
    wait_bursts(nb + 80);
    repeat (20) step();
    check("a_no_third_line", nbursts, nb + 80);
    check("a_line_count", line_count, 2);
    check("a_wait_slot_busy", busy, 1);
    check("a_wait_slot_req", m.mem_req, 0);
    check("a_no_early_swap", fb_active, 0);
    check("a_sb_empty", q.size(), 0);
    read_done = 1'b1; step(); read_done = 1'b0;
    check("a_done_idle", busy, 0);
    // frame B: 1000 pixels (31x16 + 4 beats), 3 lines consumed, swap applied at start
    hres = 11'd1000; vres = 10'd3; stride = 16'd4096;
    fb = DBL ? BASE_B : BASE_A;
    nb = nbursts;
    push_frame(fb, 4096, 500, 3);
    read_go = 1'b1; step(); read_go = 1'b0;
    check("b_swap_ack", fb_swap_ack, DBL);
    check("b_fb_active", fb_active, DBL);
    check("b_first_addr", m.mem_addr, fb);
    step();
    check("b_swap_ack_pulse", fb_swap_ack, 0);
    for (int l = 1; l <= 3; l++) begin
      t = 0;
      while (line_count < 10'(l) && t < 3000) begin
        step();
        t++;
      end
      check("b_line_reached", line_count >= 10'(l), 1);
      read_next_line = 1'b1; step(); read_next_line = 1'b0;
    end
    wait_bursts(nb + 96);
    repeat (5) step();
    check("b_drain_busy", busy, 1);
    check("b_drain_req", m.mem_req, 0);
    check("b_line_count", line_count, 3);
    check("b_no_underrun", underrun, 0);
    check("b_sb_empty", q.size(), 0);
    read_done = 1'b1; step(); read_done = 1'b0;
    check("b_done_idle", busy, 0);
    // frame C: consume before anything fetched
    hres = 11'd64; vres = 10'd4; stride = 16'd256;
    nb = nbursts;
    push_frame(fb, 256, 32, 2);
    read_go = 1'b1; step(); read_go = 1'b0;
    check("c_no_swap_ack", fb_swap_ack, 0);
    read_next_line = 1'b1; step(); read_next_line = 1'b0;
    check("c_underrun_set", underrun, 1);
    wait_bursts(nb + 4);
    repeat (10) step();
    check("c_line_count", line_count, 2);
    check("c_underrun_sticky", underrun, 1);
    check("c_sb_empty", q.size(), 0);
    read_done = 1'b1; step(); read_done = 1'b0;
    check("c_done_idle", busy, 0);
    check("c_underrun_idle", underrun, 1);
    // frame D: read_done while a burst is in flight
    lat = 10;
    nb = nbursts;
    push_frame(fb, 256, 16, 1);
    read_go = 1'b1; step(); read_go = 1'b0;
    check("d_underrun_clear", underrun, 0);
    repeat (3) step();
    read_done = 1'b1; step(); read_done = 1'b0;
    wait_bursts(nb + 1);
    check("d_idle_after_last", busy, 0);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      hits += int'(m.mem_req);
      step();
    end
    check("d_no_req_after_done", hits, 0);
    lat = 0;
    // frame E: asynchronous reset with a request pending
    mem_en = 1'b0;
    read_go = 1'b1; step(); read_go = 1'b0;
    check("e_req_pending", m.mem_req, 1);
    #3 reset = 1'b0;
    #1;
    check("e_rst_mem_req", m.mem_req, 0);
    check("e_rst_mem_addr", m.mem_addr, 0);
    check("e_rst_mem_len", m.mem_len, 0);
    check("e_rst_fb_active", fb_active, 0);
    check("e_rst_swap_ack", fb_swap_ack, 0);
    check("e_rst_busy", busy, 0);
    check("e_rst_underrun", underrun, 0);
    check("e_rst_line_count", line_count, 0);
    step();
    reset = 1'b1;
    repeat (3) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
